// File: rtl/fifo_uart_pkg.sv
// Shared types and sizing helpers for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int CNT_W            = $clog2(CLKS_PER_BIT_DEF);
    localparam int BYTE_CNT_W       = 16;

    // Counter width for an arbitrary bit period; never narrower than one bit.
    function automatic int cnt_width(input int cpb);
        return (cpb > 2) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// restart holds the count at zero so the first bit of a frame is full length.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bit_end = (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte per frame from the FIFO and shifts it out as start/data/parity/stop.
// tx and fifo_re are flop outputs; the next value is decoded from the next state.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_re,
    input  logic                  tx_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [BYTE_CNT_W-1:0] byte_count
);

    localparam int TMR_W = cnt_width(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_BIT   = (PARITY_ODD != 0);

    state_t                  r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_shift, w_shift_nxt;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    logic                    r_par, w_par_nxt;
    logic                    r_tx, w_tx_nxt;
    logic                    r_fifo_re, w_re_nxt;
    logic                    r_frame_done, w_done_nxt;
    logic [BYTE_CNT_W-1:0]   r_byte_count;
    logic                    w_bit_end;
    logic                    w_restart;

    // Timer is held in reset outside the serial states so START gets a full bit.
    assign w_restart = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (TMR_W)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .bit_end (w_bit_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_par_nxt   = r_par;
        w_re_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    w_state_nxt = FETCH;
                    w_re_nxt    = 1'b1;
                end
            end
            FETCH: w_state_nxt = LOAD;
            LOAD: begin
                w_shift_nxt = fifo_r_data;
                w_par_nxt   = (^fifo_r_data) ^ ODD_BIT;
                w_idx_nxt   = '0;
                w_state_nxt = START;
            end
            START: begin
                if (w_bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == LAST_DATA) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_idx == LAST_STOP) begin
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = w_par_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_par        <= 1'b0;
            r_tx         <= 1'b1;
            r_fifo_re    <= 1'b0;
            r_frame_done <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_idx        <= w_idx_nxt;
            r_par        <= w_par_nxt;
            r_tx         <= w_tx_nxt;
            r_fifo_re    <= w_re_nxt;
            r_frame_done <= w_done_nxt;
            if (w_done_nxt) r_byte_count <= r_byte_count + BYTE_CNT_W'(1);
        end
    end

    assign tx         = r_tx;
    assign fifo_re    = r_fifo_re;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Random and directed frames against a line-level model of the UART frame format.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        tx_en;
    logic        fifo_empty  = 1'b1;
    logic [7:0]  fifo_r_data = 8'h00;
    logic        fifo_re, tx, busy, frame_done;
    logic [15:0] byte_count;

    logic        p_empty;
    logic [7:0]  p_rdata;
    logic        pe_re, pe_tx, pe_busy, pe_done;
    logic        po_re, po_tx, po_busy, po_done;
    logic [15:0] pe_cnt, po_cnt;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data), .fifo_re(fifo_re),
        .tx_en(tx_en), .tx(tx), .busy(busy), .frame_done(frame_done), .byte_count(byte_count));

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .fifo_empty(p_empty), .fifo_r_data(p_rdata), .fifo_re(pe_re),
        .tx_en(1'b1), .tx(pe_tx), .busy(pe_busy), .frame_done(pe_done), .byte_count(pe_cnt));

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .fifo_empty(p_empty), .fifo_r_data(p_rdata), .fifo_re(po_re),
        .tx_en(1'b1), .tx(po_tx), .busy(po_busy), .frame_done(po_done), .byte_count(po_cnt));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int viol    = 0;
    int n_re    = 0;

    // Behavioural FIFO with one-cycle read latency and registered empty flag.
    logic [7:0] fq[$];
    logic       push_vld = 1'b0;
    logic [7:0] push_dat = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_re) begin
            n_re <= n_re + 1;
            if (fifo_empty) viol <= viol + 1;
            if (fq.size() > 0) fifo_r_data <= fq.pop_front();
        end
        if (push_vld) fq.push_back(push_dat);
        fifo_empty <= (fq.size() == 0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int flen(input int pen);
        return 2 + (1 + DW + pen + 1) * CPB;
    endfunction

    // Expected line level k cycles after the fetch cycle.
    function automatic logic exp_bit(input logic [7:0] b, input int k, input int pen, input int podd);
        int slot;
        if (k < 2) return 1'b1;
        slot = (k - 2) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DW) return b[slot-1];
        if (pen != 0 && slot == DW + 1) return (^b) ^ (podd != 0);
        return 1'b1;
    endfunction

    function automatic logic [63:0] exp_frame(input logic [7:0] b, input int pen, input int podd);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < flen(pen); k++) v[k] = exp_bit(b, k, pen, podd);
        return v;
    endfunction

    task automatic push(input logic [7:0] b);
        push_vld = 1'b1;
        push_dat = b;
        @(negedge clk);
        push_vld = 1'b0;
    endtask

    int exp_count = 0;
    int fetch_cyc = 0;
    int end_cyc   = 0;

    task automatic send_frame(input logic [7:0] b, input string tag, input int drop_k, input int rst_k);
        bit          ok;
        logic [63:0] v, bz;
        int          n;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fifo_re) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk({tag, "_fetch_timeout"}, 64'(0), 64'(1));
            return;
        end
        fetch_cyc = cyc;
        n  = flen(0);
        v  = '0;
        bz = '0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            v[k]  = tx;
            bz[k] = busy;
            if (k == drop_k) tx_en = 1'b0;
            if (k == rst_k) begin
                rst = 1'b1;
                @(negedge clk);
                chk({tag, "_rst_tx"}, 64'(tx), 64'(1));
                chk({tag, "_rst_busy"}, 64'(busy), 64'(0));
                chk({tag, "_rst_count"}, 64'(byte_count), 64'(0));
                chk({tag, "_rst_re"}, 64'(fifo_re), 64'(0));
                rst = 1'b0;
                exp_count = 0;
                return;
            end
        end
        end_cyc = cyc;
        chk({tag, "_tx"}, v, exp_frame(b, 0, 0));
        chk({tag, "_busy"}, bz, (64'd1 << n) - 64'd1);
        @(negedge clk);
        exp_count++;
        chk({tag, "_done"}, 64'(frame_done), 64'(1));
        chk({tag, "_idle"}, 64'(busy), 64'(0));
        chk({tag, "_count"}, 64'(byte_count), 64'(exp_count[15:0]));
    endtask

    int par_frames = 0;

    task automatic par_frame(input logic [7:0] b, input string tag);
        bit          ok;
        logic [63:0] ve, vo;
        int          n;
        p_rdata = b;
        p_empty = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pe_re) begin
                ok = 1'b1;
                break;
            end
        end
        p_empty = 1'b1;
        if (!ok) begin
            chk({tag, "_fetch_timeout"}, 64'(0), 64'(1));
            return;
        end
        chk({tag, "_odd_re"}, 64'(po_re), 64'(1));
        n  = flen(1);
        ve = '0;
        vo = '0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            ve[k] = pe_tx;
            vo[k] = po_tx;
        end
        chk({tag, "_even_tx"}, ve, exp_frame(b, 1, 0));
        chk({tag, "_odd_tx"}, vo, exp_frame(b, 1, 1));
        chk({tag, "_even_par"}, 64'(ve[2 + (1 + DW) * CPB]), 64'(^b));
        chk({tag, "_odd_par"}, 64'(vo[2 + (1 + DW) * CPB]), 64'(~^b));
        @(negedge clk);
        par_frames++;
        chk({tag, "_done"}, 64'({pe_done, po_done, pe_busy, po_busy}), 64'(4'b1100));
        chk({tag, "_count"}, 64'({pe_cnt, po_cnt}), 64'({par_frames[15:0], par_frames[15:0]}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int          bad, re0, prev_end, t0, t1, nb;
        logic [7:0]  rb[$];
        rst     = 1'b1;
        tx_en   = 1'b0;
        p_empty = 1'b1;
        p_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({tx, fifo_re, busy, frame_done}), 64'(4'b1000));
        chk("reset_count", 64'(byte_count), 64'(0));
        rst = 1'b0;

        // Single frame 0xA5
        re0 = n_re;
        push(8'hA5);
        tx_en = 1'b1;
        send_frame(8'hA5, "t1", -1, -1);
        tx_en = 1'b0;
        @(negedge clk);
        chk("t1_done_one_cycle", 64'(frame_done), 64'(0));
        chk("t1_re_pulses", 64'(n_re - re0), 64'(1));

        // Back-to-back frames
        re0 = n_re;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        tx_en = 1'b1;
        send_frame(8'h11, "t3a", -1, -1);
        prev_end = end_cyc;
        send_frame(8'h22, "t3b", -1, -1);
        chk("t3_gap_ab", 64'(fetch_cyc + 2 - prev_end - 1), 64'(3));
        prev_end = end_cyc;
        send_frame(8'h33, "t3c", -1, -1);
        chk("t3_gap_bc", 64'(fetch_cyc + 2 - prev_end - 1), 64'(3));
        chk("t3_re_pulses", 64'(n_re - re0), 64'(3));

        // Empty FIFO with transmit enabled
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_re || !tx || busy) bad++;
        end
        chk("t4_idle_quiet", 64'(bad), 64'(0));
        push(8'h3C);
        chk("t4_empty_fell", 64'(fifo_empty), 64'(0));
        t0 = cyc;
        t1 = t0 + 100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx) begin
                t1 = cyc;
                break;
            end
        end
        chk("t4_start_delay", 64'(t1 - t0), 64'(3));
        bad = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_done) begin
                bad = 0;
                break;
            end
        end
        exp_count++;
        chk("t4_done_seen", 64'(bad), 64'(0));
        chk("t4_count", 64'(byte_count), 64'(exp_count[15:0]));

        // Drop tx_en during data bit 3
        tx_en = 1'b0;
        push(8'h5A);
        push(8'h99);
        tx_en = 1'b1;
        re0 = n_re;
        send_frame(8'h5A, "t5", 2 + 4 * CPB + 1, -1);
        repeat (30) @(negedge clk);
        chk("t5_no_refetch", 64'(n_re - re0), 64'(1));
        chk("t5_fifo_left", 64'(fq.size()), 64'(1));

        // Reset during data bit 5, then recover
        tx_en = 1'b1;
        send_frame(8'h99, "t6", -1, 2 + 6 * CPB + 1);
        push(8'hC3);
        send_frame(8'hC3, "t6_after", -1, -1);
        chk("t6_fifo_empty", 64'(fq.size()), 64'(0));

        // Random bytes
        tx_en = 1'b0;
        @(negedge clk);
        nb = 4 + int'($urandom_range(0, 3));
        for (int i = 0; i < nb; i++) begin
            rb.push_back(8'($urandom));
            push(rb[i]);
        end
        tx_en = 1'b1;
        for (int i = 0; i < nb; i++) send_frame(rb[i], "rnd", -1, -1);
        tx_en = 1'b0;
        chk("no_re_while_empty", 64'(viol), 64'(0));

        // Parity variants
        par_frame(8'hA5, "t2_a5");
        par_frame(8'h07, "t2_07");
        for (int i = 0; i < 3; i++) par_frame(8'($urandom), "t2_rnd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
